frogger_input_ctrl: RTL and testbench

FROGGER_INPUT_CTRL -- requirements
Module: frogger_input_ctrl

---
 rtl/frogger_input_ctrl.sv | 152 +++++++++++++++
 tb/tb_frogger_input_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_input_ctrl.sv
// Frogger control input mapper: merges PS/2 keyboard and two pads into the active-low
// cabinet button bus, with rotation remap and a start-triggered coin pulse/lockout FSM.
module frogger_input_ctrl #(
   parameter int COIN_FRAMES = 4,
   parameter int LOCK_FRAMES = 8
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic [64:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   input  logic        vblank,
   output logic [7:0]  button_n,
   output logic        coin_busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_LOCK  = 2'd2;

   // Key-state bit order: up, down, left, right, fire, start1, start2
   function automatic logic [6:0] key_sel(input logic [7:0] code, input logic ext);
      logic [6:0] sel;
      sel = 7'b0;
      case (code)
         8'h75:        sel[0] = 1'b1;
         8'h72:        sel[1] = 1'b1;
         8'h6B:        sel[2] = 1'b1;
         8'h74:        sel[3] = 1'b1;
         8'h29, 8'h14: sel[4] = !ext;
         8'h05:        sel[5] = !ext;
         8'h06:        sel[6] = !ext;
         default:      sel = 7'b0;
      endcase
      return sel;
   endfunction

   logic        tog_p0;
   logic        armed_p0;
   logic        key_vld_p0;
   logic        pressed_p0;
   logic        ext_p0;
   logic [6:0]  key_sel_p0;
   logic [6:0]  key_p1;
   logic [15:0] joy;
   logic        unused_joy;
   logic        phys_up, phys_down, phys_left, phys_right;
   logic        up, down, left, right, fire, start1, start2;
   logic        start_any, start_any_p1, vblank_p1;
   logic        rise, vrise;
   logic [1:0]  state_p1;
   logic [7:0]  cnt_p1;

   // Stage p0: keyboard event detect and decode
   always_comb begin
      pressed_p0 = (ps2_key[15:8] != 8'hF0);
      ext_p0     = pressed_p0 ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
      key_vld_p0 = armed_p0 && (ps2_key[64] != tog_p0) && (ps2_key[63:24] == 40'b0);
      key_sel_p0 = key_sel(ps2_key[7:0], ext_p0);
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         tog_p0   <= 1'b0;
         armed_p0 <= 1'b0;
         key_p1   <= 7'b0;
      end else begin
         tog_p0   <= ps2_key[64];
         armed_p0 <= 1'b1;
         if (key_vld_p0)
            key_p1 <= (key_p1 & ~key_sel_p0) | (key_sel_p0 & {7{pressed_p0}});
      end
   end

   // Stage p1: merge sources, apply rotation before the output register
   always_comb begin
      joy        = joystick_0 | joystick_1;
      unused_joy = ^joy[15:7];
      phys_up    = key_p1[0] | joy[3];
      phys_down  = key_p1[1] | joy[2];
      phys_left  = key_p1[2] | joy[1];
      phys_right = key_p1[3] | joy[0];
      up         = rotate ? phys_left  : phys_up;
      down       = rotate ? phys_right : phys_down;
      left       = rotate ? phys_down  : phys_left;
      right      = rotate ? phys_up    : phys_right;
      fire       = key_p1[4] | joy[4];
      start1     = key_p1[5] | joy[5];
      start2     = key_p1[6] | joy[6];
      start_any  = start1 | start2;
      rise       = start_any & ~start_any_p1;
      vrise      = vblank & ~vblank_p1;
   end

   // A rise arriving outside IDLE simply finds no transition and is lost.
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         start_any_p1 <= 1'b0;
         vblank_p1    <= 1'b0;
         state_p1     <= ST_IDLE;
         cnt_p1       <= 8'd0;
      end else begin
         start_any_p1 <= start_any;
         vblank_p1    <= vblank;
         case (state_p1)
            ST_IDLE: begin
               if (rise) begin
                  state_p1 <= ST_PULSE;
                  cnt_p1   <= 8'(COIN_FRAMES);
               end
            end
            ST_PULSE: begin
               if (vrise) begin
                  if (cnt_p1 <= 8'd1) begin
                     state_p1 <= ST_LOCK;
                     cnt_p1   <= 8'(LOCK_FRAMES);
                  end else begin
                     cnt_p1 <= cnt_p1 - 8'd1;
                  end
               end
            end
            ST_LOCK: begin
               if (vrise) begin
                  if (cnt_p1 <= 8'd1) begin
                     state_p1 <= ST_IDLE;
                     cnt_p1   <= 8'd0;
                  end else begin
                     cnt_p1 <= cnt_p1 - 8'd1;
                  end
               end
            end
            default: begin
               state_p1 <= ST_IDLE;
               cnt_p1   <= 8'd0;
            end
         endcase
      end
   end

   // Stage p2: registered active-low button bus
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         button_n  <= 8'hFF;
         coin_busy <= 1'b0;
      end else begin
         button_n  <= ~{start2, fire, (state_p1 == ST_PULSE), start1, right, left, down, up};
         coin_busy <= (state_p1 != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_frogger_input_ctrl.sv
// Randomized and directed bench for frogger_input_ctrl against a rule-level reference model.
module tb_frogger_input_ctrl;

   logic        clk_sys = 1'b0;
   logic        RESET_N = 1'b0;
   logic [64:0] ps2_key = '0;
   logic [15:0] joystick_0 = '0;
   logic [15:0] joystick_1 = '0;
   logic        rotate = 1'b0;
   logic        vblank = 1'b0;
   logic [7:0]  button_n;
   logic        coin_busy;

   int   vectors = 0;
   int   miscompares = 0;
   logic tog = 1'b0;
   logic [6:0] mkey = '0;   // model key state: up, down, left, right, fire, start1, start2

   frogger_input_ctrl #(.COIN_FRAMES(4), .LOCK_FRAMES(8)) dut (
      .clk_sys    (clk_sys),
      .RESET_N    (RESET_N),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .rotate     (rotate),
      .vblank     (vblank),
      .button_n   (button_n),
      .coin_busy  (coin_busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Expected button bus from key state, merged pads, orientation and coin level.
   function automatic logic [7:0] model_btn(input logic [6:0] k, input logic [15:0] j0,
                                            input logic [15:0] j1, input logic rot,
                                            input logic coin);
      logic [15:0] j;
      logic [3:0]  phys;   // physical up, down, left, right
      logic [3:0]  lg;
      int          rot_src [4] = '{2, 3, 1, 0};
      j = j0 | j1;
      phys[0] = k[0] | j[3];
      phys[1] = k[1] | j[2];
      phys[2] = k[2] | j[1];
      phys[3] = k[3] | j[0];
      for (int i = 0; i < 4; i++) lg[i] = rot ? phys[rot_src[i]] : phys[i];
      return ~{k[6] | j[6], k[4] | j[4], coin, k[5] | j[5], lg[3], lg[2], lg[1], lg[0]};
   endfunction

   task automatic apply_reset();
      RESET_N = 1'b0;
      ps2_key = '0; joystick_0 = '0; joystick_1 = '0; rotate = 1'b0; vblank = 1'b0;
      tog = 1'b0; mkey = '0;
      tick(2);
      RESET_N = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      tick(2);
      vectors++;
      if (button_n !== 8'hFF || coin_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got button_n=%h coin_busy=%b want FF 0", button_n, coin_busy);
      end
      RESET_N = 1'b1;
      tick(3);
      vectors++;
      if (button_n !== 8'hFF || coin_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: got button_n=%h coin_busy=%b want FF 0", button_n, coin_busy);
      end
   endtask

   task automatic test_key_directed();
      apply_reset();
      tog = ~tog;
      ps2_key = {tog, 40'b0, 8'h00, 8'h00, 8'h75};
      tick(1);
      vectors++;
      if (button_n !== 8'hFF) begin
         miscompares++;
         $display("FAIL key_up_latency1: got %h want FF", button_n);
      end
      tick(1);
      vectors++;
      if (button_n !== 8'hFE) begin
         miscompares++;
         $display("FAIL key_up_press: got %h want FE", button_n);
      end
      tog = ~tog;
      ps2_key = {tog, 40'b0, 8'h00, 8'hF0, 8'h75};
      tick(2);
      vectors++;
      if (button_n !== 8'hFF) begin
         miscompares++;
         $display("FAIL key_up_release: got %h want FF", button_n);
      end
   endtask

   task automatic test_key_random();
      logic [7:0]  codes [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06, 8'h1C, 8'h5A};
      logic [7:0]  b1s [3] = '{8'h00, 8'hE0, 8'hF0};
      logic [7:0]  code, b1, b2;
      logic [39:0] hi;
      logic        pressed, ext;
      logic [7:0]  exp;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         code = codes[$urandom_range(0, 9)];
         b1   = b1s[$urandom_range(0, 2)];
         b2   = ($urandom_range(0, 1) == 1) ? 8'hE0 : 8'h00;
         hi   = ($urandom_range(0, 7) == 0) ? 40'(1 << $urandom_range(0, 31)) : 40'b0;
         joystick_0 = 16'($urandom) & 16'h005F;
         joystick_1 = 16'($urandom) & 16'h001F;
         rotate     = 1'($urandom);
         if (hi == 40'b0) begin
            pressed = (b1 != 8'hF0);
            ext = pressed ? (b1 == 8'hE0) : (b2 == 8'hE0);
            case (code)
               8'h75: mkey[0] = pressed;
               8'h72: mkey[1] = pressed;
               8'h6B: mkey[2] = pressed;
               8'h74: mkey[3] = pressed;
               8'h29, 8'h14: if (!ext) mkey[4] = pressed;
               8'h05: if (!ext) mkey[5] = pressed;
               8'h06: if (!ext) mkey[6] = pressed;
               default: ;
            endcase
         end
         tog = ~tog;
         ps2_key = {tog, hi, b2, b1, code};
         tick(2);
         exp = model_btn(mkey, joystick_0, joystick_1, rotate, 1'b0);
         vectors++;
         if ((button_n | 8'h20) !== (exp | 8'h20)) begin
            miscompares++;
            $display("FAIL key_random[%0d] code=%h pfx=%h/%h hi=%h: got %h want %h",
                     i, code, b2, b1, hi, button_n | 8'h20, exp | 8'h20);
         end
      end
   endtask

   task automatic test_joy_rotate();
      logic [7:0] exp;
      apply_reset();
      rotate = 1'b1;
      joystick_0 = 16'h0002;
      tick(1);
      vectors++;
      if (button_n !== 8'hFE) begin
         miscompares++;
         $display("FAIL rot_left_to_up: got %h want FE", button_n);
      end
      joystick_0 = 16'h0000;
      tick(1);
      vectors++;
      if (button_n !== 8'hFF) begin
         miscompares++;
         $display("FAIL rot_release: got %h want FF", button_n);
      end
      for (int i = 0; i < 16; i++) begin
         joystick_0 = 16'($urandom);
         joystick_1 = 16'($urandom);
         rotate     = 1'($urandom);
         tick(1);
         exp = model_btn(7'b0, joystick_0, joystick_1, rotate, 1'b0);
         vectors++;
         if ((button_n | 8'h20) !== (exp | 8'h20)) begin
            miscompares++;
            $display("FAIL joy_random[%0d] j0=%h j1=%h rot=%b: got %h want %h",
                     i, joystick_0, joystick_1, rotate, button_n | 8'h20, exp | 8'h20);
         end
      end
   endtask

   task automatic test_coin();
      logic exp_coin_n, exp_busy;
      apply_reset();
      // start rise together with a vrise: that vrise must not count
      joystick_1 = 16'h0020;
      vblank = 1'b1;
      tick(1);
      vectors++;
      if (button_n[5] !== 1'b1) begin
         miscompares++;
         $display("FAIL coin_latency1: got %b want 1", button_n[5]);
      end
      joystick_1 = 16'h0000;
      vblank = 1'b0;
      tick(1);
      vectors++;
      if (button_n[5] !== 1'b0 || coin_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL coin_latency2: got coin_n=%b busy=%b want 0 1", button_n[5], coin_busy);
      end
      for (int v = 1; v <= 13; v++) begin
         vblank = 1'b1;
         tick(1);
         vblank = 1'b0;
         tick(3);
         exp_coin_n = (v < 4) ? 1'b0 : 1'b1;
         exp_busy   = (v < 12);
         vectors++;
         if (button_n[5] !== exp_coin_n || coin_busy !== exp_busy) begin
            miscompares++;
            $display("FAIL coin_vrise[%0d]: got coin_n=%b busy=%b want %b %b",
                     v, button_n[5], coin_busy, exp_coin_n, exp_busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_coin_n, exp_busy;
      apply_reset();
      joystick_0 = 16'h0040;
      tick(1);
      joystick_0 = 16'h0000;
      tick(2);
      for (int v = 1; v <= 12; v++) begin
         vblank = 1'b1;
         if (v == 12) joystick_0 = 16'h0040;   // rise on the LOCKOUT->IDLE cycle
         tick(1);
         vblank = 1'b0;
         joystick_0 = 16'h0000;
         tick(1);
         if (v == 6) begin
            joystick_0 = 16'h0040;             // rise during LOCKOUT
            tick(1);
            joystick_0 = 16'h0000;
         end
         tick(2);
         exp_coin_n = (v < 4) ? 1'b0 : 1'b1;
         exp_busy   = (v < 12);
         vectors++;
         if (button_n[5] !== exp_coin_n || coin_busy !== exp_busy) begin
            miscompares++;
            $display("FAIL drop_vrise[%0d]: got coin_n=%b busy=%b want %b %b",
                     v, button_n[5], coin_busy, exp_coin_n, exp_busy);
         end
      end
      tick(4);
      vectors++;
      if (button_n !== 8'hFF || coin_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_after: got button_n=%h busy=%b want FF 0", button_n, coin_busy);
      end
   endtask

   task automatic test_reset_mid_pulse();
      apply_reset();
      joystick_1 = 16'h0040;
      tick(1);
      joystick_1 = 16'h0000;
      tick(2);
      vectors++;
      if (button_n[5] !== 1'b0 || coin_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midpulse_pre: got coin_n=%b busy=%b want 0 1", button_n[5], coin_busy);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      vectors++;
      if (button_n !== 8'hFF || coin_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got button_n=%h busy=%b want FF 0", button_n, coin_busy);
      end
      ps2_key = {1'b1, 40'b0, 8'h00, 8'h00, 8'h75};
      tick(2);
      RESET_N = 1'b1;
      tick(3);
      vectors++;
      if (button_n !== 8'hFF || coin_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL armed_release: got button_n=%h busy=%b want FF 0", button_n, coin_busy);
      end
   endtask

   initial begin
      test_reset();
      test_key_directed();
      test_key_random();
      test_joy_rotate();
      test_coin();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
